// File: rtl/multi_key_detector_if.sv
// rtl/multi_key_detector_if.sv - key detector bus: raw key levels in, debounced levels/pulses/key code out
interface multi_key_detector_if #(
  parameter int N_KEYS = 4
);
  localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] sw_in;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_multi;

  modport master (
    output sw_in,
    input  key_state, key_press, key_release, key_valid, key_code, key_multi
  );

  modport slave (
    input  sw_in,
    output key_state, key_press, key_release, key_valid, key_code, key_multi
  );
endinterface

// File: rtl/multi_key_detector.sv
// rtl/multi_key_detector.sv - N-channel sync/debounce key detector with press encoder; KEY_AUTOREPEAT_EN adds auto-repeat
module multi_key_detector #(
  parameter int N_KEYS        = 4,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input logic                 clk,
  input logic                 reset,
  multi_key_detector_if.slave key_bus
);
  localparam int CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_state;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [CNT_W-1:0]  r_cnt [N_KEYS];
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_multi;

  logic [N_KEYS-1:0] w_toggle;
  logic [N_KEYS-1:0] w_repeat;
  logic [CODE_W-1:0] w_code;
  logic              w_multi;

  // Toggle on the cycle the mismatch count would reach DB_CYCLES
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_toggle[i] = (r_sync2[i] != r_state[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= key_bus.sw_in;
      r_sync2   <= r_sync1;
      r_state   <= r_state ^ w_toggle;
      r_press   <= (w_toggle & ~r_state) | w_repeat;
      r_release <= w_toggle & r_state;
      for (int i = 0; i < N_KEYS; i++) begin
        if ((r_sync2[i] == r_state[i]) || w_toggle[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] r_hold [N_KEYS];

  // Down-counter per held key; a release toggle wins over a due repeat
  always_comb begin
    w_repeat = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_repeat[i] = r_state[i] && !w_toggle[i] && (r_hold[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_toggle[i]) begin
          r_hold[i] <= r_state[i] ? '0 : HOLD_DELAY;
        end else if (r_state[i]) begin
          r_hold[i] <= (r_hold[i] == '0) ? HOLD_PERIOD : r_hold[i] - 1'b1;
        end
      end
    end
  end
`else
  assign w_repeat = '0;
`endif

  always_comb begin
    w_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (r_press[i]) begin
        w_code = CODE_W'(i);
      end
    end
    w_multi = ((r_press & (r_press - 1'b1)) != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_multi <= 1'b0;
    end else begin
      r_valid <= |r_press;
      r_code  <= w_code;
      r_multi <= w_multi;
    end
  end

  assign key_bus.key_state   = r_state;
  assign key_bus.key_press   = r_press;
  assign key_bus.key_release = r_release;
  assign key_bus.key_valid   = r_valid;
  assign key_bus.key_code    = r_code;
  assign key_bus.key_multi   = r_multi;
endmodule

// File: tb/tb_multi_key_detector.sv
// tb/tb_multi_key_detector.sv - scoreboard bench for multi_key_detector
module tb_multi_key_detector;
  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   mon_en;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] state;
  } pulse_t;

  typedef struct {
    int         cyc;
    logic [1:0] code;
    logic       multi;
  } enc_t;

  pulse_t q_pulse[$];
  enc_t   q_enc[$];

  multi_key_detector_if #(.N_KEYS(4)) kif ();

  multi_key_detector #(
    .N_KEYS(4), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_bus(kif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
    pulse_t e;
    e.cyc = c; e.press = p; e.rel = r; e.state = s;
    q_pulse.push_back(e);
  endtask

  task automatic push_enc(input int c, input logic [1:0] code, input logic multi);
    enc_t e;
    e.cyc = c; e.code = code; e.multi = multi;
    q_enc.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if ((|kif.key_press) || (|kif.key_release)) begin
        if (q_pulse.size() == 0) begin
          chk("unexpected_pulse", {kif.key_press, kif.key_release}, 0);
        end else begin
          pulse_t e;
          e = q_pulse.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("key_press", kif.key_press, e.press);
          chk("key_release", kif.key_release, e.rel);
          chk("key_state", kif.key_state, e.state);
        end
      end
      if (kif.key_valid) begin
        if (q_enc.size() == 0) begin
          chk("unexpected_valid", kif.key_code, 4'hf);
        end else begin
          enc_t e;
          e = q_enc.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("key_code", kif.key_code, e.code);
          chk("key_multi", kif.key_multi, e.multi);
        end
      end
    end
  end

  initial begin
    int c;
    n_cmp = 0;
    n_bad = 0;
    mon_en = 0;
    reset = 1'b0;
    kif.sw_in = 4'b1111;

    // Reset held 3 cycles with all keys down
    @(negedge clk);
    mon_en = 1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_state", kif.key_state, 0);
      chk("rst_press", kif.key_press, 0);
      chk("rst_outs", {kif.key_release, kif.key_valid, kif.key_code, kif.key_multi}, 0);
      if (i < 2) @(negedge clk);
    end
    reset = 1'b1;
    c = cyc;
    push_pulse(c + 6, 4'b1111, 4'b0000, 4'b1111);
    push_enc(c + 7, 2'd0, 1'b1);
    wait_cyc(12);
    kif.sw_in = 4'b0000; c = cyc;
    push_pulse(c + 6, 4'b0000, 4'b1111, 4'b0000);
    wait_cyc(12);

    // Clean press of ch2
    kif.sw_in = 4'b0100; c = cyc;
    push_pulse(c + 6, 4'b0100, 4'b0000, 4'b0100);
    push_enc(c + 7, 2'd2, 1'b0);
    wait_cyc(12);
    kif.sw_in = 4'b0000; c = cyc;
    push_pulse(c + 6, 4'b0000, 4'b0100, 4'b0000);
    wait_cyc(12);

    // Bounce on ch0, then a 3-cycle glitch, then a real press
    for (int i = 0; i < 10; i++) begin
      kif.sw_in = 4'b0001; wait_cyc(1);
      kif.sw_in = 4'b0000; wait_cyc(1);
    end
    wait_cyc(4);
    kif.sw_in = 4'b0001; wait_cyc(3);
    kif.sw_in = 4'b0000; wait_cyc(8);
    chk("glitch_state", kif.key_state, 0);
    kif.sw_in = 4'b0001; c = cyc;
    push_pulse(c + 6, 4'b0001, 4'b0000, 4'b0001);
    push_enc(c + 7, 2'd0, 1'b0);
    wait_cyc(12);
    kif.sw_in = 4'b0000; c = cyc;
    push_pulse(c + 6, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(12);

    // Simultaneous press/release of ch1 and ch3
    kif.sw_in = 4'b1010; c = cyc;
    push_pulse(c + 6, 4'b1010, 4'b0000, 4'b1010);
    push_enc(c + 7, 2'd1, 1'b1);
    wait_cyc(12);
    kif.sw_in = 4'b0000; c = cyc;
    push_pulse(c + 6, 4'b0000, 4'b1010, 4'b0000);
    wait_cyc(12);

    // Reset pulsed on the 3rd edge of a ch2 debounce
    kif.sw_in = 4'b0100; c = cyc;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    chk("middb_state", kif.key_state, 0);
    reset = 1'b1;
    push_pulse(c + 9, 4'b0100, 4'b0000, 4'b0100);
    push_enc(c + 10, 2'd2, 1'b0);
    wait_cyc(12);
    chk("middb_held", kif.key_state, 4'b0100);
    kif.sw_in = 4'b0000; c = cyc;
    push_pulse(c + 6, 4'b0000, 4'b0100, 4'b0000);
    wait_cyc(12);

    // ch0 accepted at t0, key_state held 60 cycles
    kif.sw_in = 4'b0001; c = cyc;
    push_pulse(c + 6, 4'b0001, 4'b0000, 4'b0001);
    push_enc(c + 7, 2'd0, 1'b0);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = 20; t <= 52; t += (t == 20) ? 8 : 8) begin
      push_pulse(c + 6 + t, 4'b0001, 4'b0000, 4'b0001);
      push_enc(c + 7 + t, 2'd0, 1'b0);
    end
`endif
    wait_cyc(60);
    kif.sw_in = 4'b0000;
    push_pulse(c + 66, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(30);

    chk("pulse_q_left", q_pulse.size(), 0);
    chk("enc_q_left", q_enc.size(), 0);
    chk("final_state", kif.key_state, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_key_detector.md
# multi_key_detector

Parametrised multi-channel successor to the single-switch key detector for the candy vending system. It samples N raw push-button inputs. For each channel it synchronises and debounces the input, then emits a clean level plus one-cycle press and release pulses. It also encodes the highest-priority new press into a key code for the vending controller, and can optionally auto-repeat held keys.

## Interface
- N_KEYS, 4: number of independent key channels (1..16).
- DB_CYCLES, 4: consecutive stable synchronised cycles required to accept a level change (≥1).
- REPEAT_DELAY, 20: cycles from a press pulse to the first auto-repeat pulse (≥2; used only with auto-repeat).
- REPEAT_PERIOD, 8: cycles between subsequent auto-repeat pulses (≥2; used only with auto-repeat).
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- sw_in  input  N_KEYS  raw, asynchronous, bouncing key levels (1 = pressed).
- key_state  output  N_KEYS  debounced key levels.
- key_press  output  N_KEYS  one-cycle pulse per channel on an accepted press (or repeat).
- key_release  output  N_KEYS  one-cycle pulse per channel on an accepted release.
- key_valid  output  1  one-cycle strobe: key_code holds a new event.
- key_code  output  clog2(N_KEYS) (min 1)  index of the lowest-numbered channel in the previous cycle's key_press.
- key_multi  output  1  qualifies key_valid: more than one bit of the previous cycle's key_press was set.

## Operation
- Per channel, a two-flop synchroniser (sync1 → sync2) feeds a debounce counter of width clog2(DB_CYCLES+1).
- Debounce counter rules:
  - When sync2 == key_state, the counter clears to 0.
  - When sync2 != key_state, the counter increments.
  - When the counter would reach DB_CYCLES, key_state toggles and the counter clears.
- A glitch shorter than DB_CYCLES synchronised cycles never changes key_state. Any return to the accepted level restarts the count.
- key_press[i] / key_release[i] are registered together with the key_state[i] toggle (0→1 and 1→0 respectively) and last exactly one cycle.
- Encoder rules:
  - key_valid = OR of the previous cycle's key_press.
  - key_code = lowest set index of that vector; higher simultaneous presses are not queued.
  - key_multi = 1 if that vector had ≥2 bits set.
- Channels are fully independent; simultaneous events on any channels are handled in the same cycle.

## Timing
- Reset (reset low at a rising edge): sync flops, counters, and repeat counters clear; all outputs are 0 from the next cycle.
- Reset mid-debounce or mid-repeat discards progress; no pulse is emitted for the aborted event.
- Press latency: sw_in stable from sampling edge k → key_state and key_press change at edge k+1+DB_CYCLES. The total is DB_CYCLES+2 edges, counting edge k.
- key_valid, key_code, and key_multi follow key_press by exactly one cycle.
- While reset is low, no pulses are generated regardless of sw_in. After release, keys already held are accepted as a normal press after the latency above.

## Configuration
- KEY_AUTOREPEAT_EN defined:
  - Each channel has a hold counter that runs while key_state[i]=1.
  - An additional key_press[i] pulse is emitted REPEAT_DELAY cycles after the original press pulse, then every REPEAT_PERIOD cycles while the key is held.
  - Release or reset clears the hold counter immediately; no repeat pulse is emitted in the release cycle.
  - Repeat pulses drive the encoder exactly like presses.
- KEY_AUTOREPEAT_EN undefined:
  - No hold counters are synthesised; REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Exactly one key_press per accepted press.

## Test plan
All scenarios use N_KEYS=4, DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, clk period 20 ns.
- Reset: hold reset low 3 cycles with sw_in=4'b1111 → all outputs 0 during reset. After release, key_state=4'b1111 with key_press=4'b1111 at the 6th edge; key_valid=1, key_code=0, key_multi=1 one cycle later.
- Clean press: sw_in 4'b0000→4'b0100 held → key_state[2]=1 and key_press=4'b0100 for one cycle 6 edges after the first sample; next cycle key_valid=1, key_code=2, key_multi=0.
- Bounce/glitch: ch0 toggling 1-cycle high, 1-cycle low for 10 cycles, then a 3-cycle high pulse → key_state[0] stays 0, no pulses. Then hold high → key_press[0] once, 6 edges after the stable level starts.
- Simultaneous press and release: ch1 and ch3 pressed the same cycle → key_press=4'b1010, key_code=1, key_multi=1. Release both → key_release=4'b1010 one cycle, key_valid stays 0.
- Reset mid-debounce: ch2 rises, reset pulsed low 1 cycle at the 3rd edge → no key_press. After reset, the input still high is accepted a full 6 edges later.
- Auto-repeat: hold ch0 for 60 cycles after acceptance.
  - With KEY_AUTOREPEAT_EN → key_press[0] pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52.
  - Without the macro → only the t0 pulse.
  - In both cases, release gives one key_release[0] and no further presses.
